// File: rtl/kogge_stone_8bit_adder.sv
// 8-bit Kogge-Stone parallel-prefix adder with carry-in/carry-out, result registered (1-cycle latency).
// The prefix tree is built from explicit generate/propagate cells, three full-width levels.

module ks_gp_cell (
  input  logic g_hi_i,
  input  logic p_hi_i,
  input  logic g_lo_i,
  input  logic p_lo_i,
  output logic g_o,
  output logic p_o
);
  assign g_o = g_hi_i | (p_hi_i & g_lo_i);
  assign p_o = p_hi_i & p_lo_i;
endmodule

module kogge_stone_8bit_adder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);
  localparam int W      = 8;
  localparam int LEVELS = 3;

  logic [W-1:0] g_bit, p_bit;
  logic [LEVELS:0][W-1:0] g_lvl, p_lvl;
  logic [W-1:0] carry;
  logic [W-1:0] s_d, s_q;
  logic         cout_d, cout_q;
  logic         unused_p;

  assign g_bit = a & b;
  assign p_bit = a ^ b;

  // cin sits at position -1 with P=0; folding it into bit 0 ahead of the span-1 row lets
  // eight nodes cover all nine positions in three levels. Bit 0 then carries P=0.
  ks_gp_cell u_cin_fold (
    .g_hi_i(g_bit[0]), .p_hi_i(p_bit[0]),
    .g_lo_i(cin),      .p_lo_i(1'b0),
    .g_o   (g_lvl[0][0]), .p_o(p_lvl[0][0])
  );

  for (genvar i = 1; i < W; i++) begin : g_l0
    assign g_lvl[0][i] = g_bit[i];
    assign p_lvl[0][i] = p_bit[i];
  end

  for (genvar lv = 1; lv <= LEVELS; lv++) begin : g_lvl_row
    localparam int SPAN = 1 << (lv - 1);
    for (genvar i = 0; i < W; i++) begin : g_node
      if (i >= SPAN) begin : g_cell
        ks_gp_cell u_cell (
          .g_hi_i(g_lvl[lv-1][i]),      .p_hi_i(p_lvl[lv-1][i]),
          .g_lo_i(g_lvl[lv-1][i-SPAN]), .p_lo_i(p_lvl[lv-1][i-SPAN]),
          .g_o   (g_lvl[lv][i]),        .p_o   (p_lvl[lv][i])
        );
      end else begin : g_pass
        assign g_lvl[lv][i] = g_lvl[lv-1][i];
        assign p_lvl[lv][i] = p_lvl[lv-1][i];
      end
    end
  end

  // Group propagates out of the last row have no consumer.
  assign unused_p = ^p_lvl[LEVELS];

  // c_0 = cin, c_{i+1} = G[i:-1]
  assign carry  = {g_lvl[LEVELS][W-2:0], cin};
  assign s_d    = p_bit ^ carry;
  assign cout_d = g_lvl[LEVELS][W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
    end
  end

  assign s    = s_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_kogge_stone_8bit_adder.sv
// Self-checking bench: directed vectors, reset cases, random back-to-back and an a/b sweep
// against an arithmetic reference (a+b+cin), one cycle delayed.

module tb_kogge_stone_8bit_adder;
  logic       clk;
  logic       rst_n;
  logic [7:0] a, b;
  logic       cin;
  logic [7:0] s;
  logic       cout;

  int n_chk = 0;
  int n_err = 0;

  kogge_stone_8bit_adder dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .s(s), .cout(cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got {cout,s}=%03h expected %03h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ref_sum(input logic [7:0] x, input logic [7:0] y, input logic c);
    int unsigned t;
    t = int'(x) + int'(y) + int'(c);
    return t[8:0];
  endfunction

  // Apply one operand set, let one edge capture it, check just after the edge.
  task automatic step(input string tag, input logic [7:0] x, input logic [7:0] y, input logic c);
    a = x; b = y; cin = c;
    @(posedge clk); #1;
    chk(tag, {cout, s}, ref_sum(x, y, c));
  endtask

  // Directed vectors with spec-derived expected values.
  task automatic dir(input string tag, input logic [7:0] x, input logic [7:0] y, input logic c,
                     input logic [8:0] exp);
    a = x; b = y; cin = c;
    @(posedge clk); #1;
    chk(tag, {cout, s}, exp);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc;

    // Reset asserted before the first clock edge, with non-zero inputs.
    rst_n = 1'b1; a = 8'hAB; b = 8'hCD; cin = 1'b1;
    #1 rst_n = 1'b0;
    #2 chk("reset_async", {cout, s}, 9'h000);
    @(posedge clk); #1;
    chk("reset_hold", {cout, s}, 9'h000);
    #2 rst_n = 1'b1;

    dir("vec_00_00_0", 8'h00, 8'h00, 1'b0, 9'h000);
    dir("vec_F0_0F_0", 8'hF0, 8'h0F, 1'b0, 9'h0FF);
    dir("vec_B5_D6_1", 8'hB5, 8'hD6, 1'b1, 9'h18C);
    dir("vec_69_5C_1", 8'h69, 8'h5C, 1'b1, 9'h0C6);
    dir("vec_AA_55_0", 8'hAA, 8'h55, 1'b0, 9'h0FF);
    dir("ripple_FF_00_1", 8'hFF, 8'h00, 1'b1, 9'h100);
    dir("max_FF_FF_1", 8'hFF, 8'hFF, 1'b1, 9'h1FF);
    dir("single_01_7F_0", 8'h01, 8'h7F, 1'b0, 9'h080);
    dir("cin_only_00_00_1", 8'h00, 8'h00, 1'b1, 9'h001);

    // Back-to-back random operands, new set every edge.
    for (int k = 0; k < 200; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      step("b2b_rand", ra, rb, rc);
    end

    // Mid-stream reset: result pending at the output, drop rst_n between edges.
    step("pre_reset", 8'hFF, 8'hFF, 1'b1);
    a = 8'h12; b = 8'h34; cin = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("reset_midstream", {cout, s}, 9'h000);
    #2 rst_n = 1'b1;
    step("post_reset", 8'h9C, 8'h7B, 1'b1);
    step("post_reset2", 8'h80, 8'h80, 1'b0);

    // Sweep every a/b pair; cin randomised per pair to keep the run short.
    for (int x = 0; x < 256; x++) begin
      for (int y = 0; y < 256; y++) begin
        rc = 1'($urandom);
        step("sweep", 8'(x), 8'(y), rc);
      end
    end

    // Both cin values on every carry-chain-sensitive a with b = ~a.
    for (int x = 0; x < 256; x++) begin
      step("cmpl_c0", 8'(x), ~8'(x), 1'b0);
      step("cmpl_c1", 8'(x), ~8'(x), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
